// File: rtl/pc_fetch_stage.sv
// Instruction-fetch stage: owns the word-addressed fetch PC, drives instruction memory
// and loads the IF/ID register, with branch/jump redirect, stall and HALT handling.
module pc_fetch_stage #(
  parameter int                     PC_WIDTH    = 10,
  parameter int                     INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_target,
  input  logic                   jump,
  input  logic [PC_WIDTH-1:0]    jump_target,
  input  logic                   halt,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  output logic [PC_WIDTH-1:0]    if_pc,
  output logic [PC_WIDTH-1:0]    if_pc_plus1,
  output logic [INSTR_WIDTH-1:0] if_instr,
  output logic                   if_valid,
  output logic                   halted
);

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALTED} state_e;

  state_e                 state_q, state_d;
  logic [PC_WIDTH-1:0]    fetch_pc_q, fetch_pc_d;
  logic [PC_WIDTH-1:0]    if_pc_q, if_pc_d;
  logic [INSTR_WIDTH-1:0] if_instr_q, if_instr_d;
  logic                   if_valid_q, if_valid_d;

  logic                   load_pc;
  logic [PC_WIDTH-1:0]    load_val;
  logic                   flush;
  logic                   advance;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      fetch_pc_q <= RESET_PC;
      if_pc_q    <= '0;
      if_instr_q <= NOP_INSTR;
      if_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      if_valid_q <= if_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT:   state_d = ST_RUN;
      ST_RUN:    if (!branch_taken && !jump && halt) state_d = ST_HALTED;
      ST_HALTED: if (branch_taken) state_d = ST_RUN;
      default:   state_d = ST_BOOT;
    endcase
  end

  // Control strobes; a taken branch outranks a jump because it is the older instruction.
  always_comb begin
    load_pc  = 1'b0;
    load_val = fetch_pc_q;
    flush    = 1'b0;
    advance  = 1'b0;
    halted   = (state_q == ST_HALTED);
    case (state_q)
      ST_RUN: begin
        if (branch_taken) begin
          load_pc  = 1'b1;
          load_val = branch_target;
          flush    = 1'b1;
        end else if (jump) begin
          load_pc  = 1'b1;
          load_val = jump_target;
          flush    = 1'b1;
        end else if (halt) begin
          flush    = 1'b1;
        end else if (!stall) begin
          advance  = 1'b1;
        end
      end
      ST_HALTED: begin
        if (branch_taken) begin
          load_pc  = 1'b1;
          load_val = branch_target;
          flush    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    if_valid_d = if_valid_q;
    if (load_pc) begin
      fetch_pc_d = load_val;
    end else if (advance) begin
      fetch_pc_d = fetch_pc_q + PC_WIDTH'(1);
    end
    if (flush) begin
      if_instr_d = NOP_INSTR;
      if_valid_d = 1'b0;
    end else if (advance) begin
      if_instr_d = imem_data;
      if_pc_d    = fetch_pc_q;
      if_valid_d = 1'b1;
    end
  end

  assign imem_addr   = fetch_pc_q;
  assign if_pc       = if_pc_q;
  assign if_pc_plus1 = if_pc_q + PC_WIDTH'(1);
  assign if_instr    = if_instr_q;
  assign if_valid    = if_valid_q;

endmodule
